// File: rtl/uart_byte_rx_if.sv
//==============================================================================
// Module  : uart_byte_rx_if
// Desc    : Line and byte-side signals of the serial byte receiver; parity_err
//           exists only when UART_RX_PARITY_EN is defined.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface uart_byte_rx_if;
  logic       rx;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (output rx, input data_byte, rx_done, frame_err, busy, parity_err);
  modport slave  (input rx, output data_byte, rx_done, frame_err, busy, parity_err);
`else
  modport master (output rx, input data_byte, rx_done, frame_err, busy);
  modport slave  (input rx, output data_byte, rx_done, frame_err, busy);
`endif
endinterface

`default_nettype wire

// File: rtl/uart_byte_rx.sv
//==============================================================================
// Module  : uart_byte_rx
// Desc    : Async 8-N-1 serial to byte receiver with rx_done/frame_err strobes.
//           Define UART_RX_PARITY_EN for an even-parity bit and parity_err.
// Revision: 1.0
//==============================================================================
`default_nettype none

module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic           Clk,
  input  logic           Rst,
  uart_byte_rx_if.slave  bus
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int c_CNT_W  = $clog2(BAUD_DIV);

  localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(BAUD_DIV - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  logic               r_sync1;
  logic               r_sync2;
  logic               r_prev;
  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_baud_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic [7:0]         r_data;
  logic               r_done;
  logic               r_ferr;
  logic               r_busy;
  logic               w_fall;
`ifdef UART_RX_PARITY_EN
  logic               r_par;
  logic               r_perr;
`endif

  // Two-stage synchronizer plus edge flop; all idle high.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = r_prev & ~r_sync2;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= c_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_data     <= 8'h00;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par      <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      case (r_state)
        c_IDLE: begin
          if (w_fall) begin
            r_state    <= c_START;
            r_baud_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        c_START: begin
          if (r_baud_cnt == c_HALF_M1) begin
            r_baud_cnt <= '0;
            if (r_sync2) begin
              r_state <= c_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_bit_cnt <= 3'd0;
              r_state   <= c_DATA;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        c_DATA: begin
          if (r_baud_cnt == c_FULL_M1) begin
            r_shift[r_bit_cnt] <= r_sync2;
            r_baud_cnt         <= '0;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= c_PARITY;
`else
              r_state <= c_STOP;
`endif
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        c_PARITY: begin
          if (r_baud_cnt == c_FULL_M1) begin
            r_par      <= r_sync2;
            r_baud_cnt <= '0;
            r_state    <= c_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
`endif
        c_STOP: begin
          // Leaving at mid stop bit keeps a back-to-back start edge visible.
          if (r_baud_cnt == c_FULL_M1) begin
            r_baud_cnt <= '0;
            r_state    <= c_IDLE;
            r_busy     <= 1'b0;
            if (!r_sync2) begin
              r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{r_shift, r_par}) begin
              r_perr <= 1'b1;
`endif
            end else begin
              r_data <= r_shift;
              r_done <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= c_IDLE;
          r_baud_cnt <= '0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_byte = r_data;
  assign bus.rx_done   = r_done;
  assign bus.frame_err = r_ferr;
  assign bus.busy      = r_busy;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = r_perr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
//==============================================================================
// Module  : tb_uart_byte_rx
// Desc    : Directed bench for uart_byte_rx at default rates (1 bit = 434 Clk).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_uart_byte_rx;

  localparam int BIT_T = 434;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  uart_byte_rx_if bus ();

  uart_byte_rx dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #10 Clk = ~Clk;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int busy_cyc = 0;
  int last_done_cyc = 0;
  logic [7:0] got [$];

  always @(negedge Clk) begin
    cyc <= cyc + 1;
    if (bus.busy) busy_cyc <= busy_cyc + 1;
    if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (bus.parity_err) perr_cnt <= perr_cnt + 1;
`endif
    if (bus.rx_done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
      got.push_back(bus.data_byte);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    idle(BIT_T);
  endtask

  // Parity bit (when built in) is even parity, optionally inverted.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`else
    if (par_flip) idle(0);
`endif
    send_bit(stop);
  endtask

  task automatic test_reset;
    Rst    = 1'b0;
    bus.rx = 1'b1;
    idle(5);
    checks++; if (bus.data_byte !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", bus.data_byte); end
    checks++; if (bus.rx_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.rx_done); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", bus.frame_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    Rst = 1'b1;
    idle(10);
  endtask

  task automatic test_single;
    int d0, f0, t0, lat;
    d0 = done_cnt; f0 = ferr_cnt;
    @(negedge Clk);
    t0 = cyc;
    send_frame(8'h48, 1'b1, 1'b0);
    idle(20);
    lat = last_done_cyc - t0;
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (bus.data_byte !== 8'h48) begin errors++; $display("FAIL single_data got=%h exp=48", bus.data_byte); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", bus.busy); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL single_ferr got=%0d exp=0", ferr_cnt - f0); end
`ifndef UART_RX_PARITY_EN
    checks++; if (lat < 4115 || lat > 4135) begin errors++; $display("FAIL single_latency got=%0d exp=4115..4135", lat); end
`else
    checks++; if (lat < 4549 || lat > 4569) begin errors++; $display("FAIL single_latency got=%0d exp=4549..4569", lat); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [5];
    int d0, f0;
    exp[0] = 8'h48; exp[1] = 8'h45; exp[2] = 8'h4C; exp[3] = 8'h4C; exp[4] = 8'h4F;
    d0 = done_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 5; i++) send_frame(exp[i], 1'b1, 1'b0);
    idle(50);
    checks++; if (done_cnt - d0 !== 5) begin errors++; $display("FAIL b2b_done_count got=%0d exp=5", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_ferr got=%0d exp=0", ferr_cnt - f0); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got.size() <= d0 + i) begin
        errors++; $display("FAIL b2b_byte%0d got=missing exp=%h", i, exp[i]);
      end else if (got[d0 + i] !== exp[i]) begin
        errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got[d0 + i], exp[i]);
      end
    end
  endtask

  task automatic test_glitch;
    int d0, f0, b0;
    d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cyc;
    bus.rx = 1'b0;
    idle(100);
    bus.rx = 1'b1;
    idle(400);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (busy_cyc - b0 < 200 || busy_cyc - b0 > 218) begin errors++; $display("FAIL glitch_busy_len got=%0d exp=200..218", busy_cyc - b0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got=%b exp=0", bus.busy); end
  endtask

  task automatic test_frame_err;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    bus.rx = 1'b1;
    idle(100);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ferr_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (bus.data_byte !== 8'h41) begin errors++; $display("FAIL ferr_data got=%h exp=41", bus.data_byte); end
  endtask

  task automatic test_break;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    bus.rx = 1'b0;
    idle(25 * BIT_T);
    bus.rx = 1'b1;
    idle(2 * BIT_T);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL break_ferr got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL break_done got=%0d exp=0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    int d0, f0;
    logic [7:0] b;
    b = 8'hA5;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    idle(BIT_T / 2);
    Rst = 1'b0;
    bus.rx = 1'b1;
    idle(5);
    Rst = 1'b1;
    idle(20);
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (bus.data_byte !== 8'h3C) begin errors++; $display("FAIL rstmid_data got=%h exp=3C", bus.data_byte); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL rstmid_ferr got=%0d exp=0", ferr_cnt - f0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int d0, p0;
    d0 = done_cnt; p0 = perr_cnt;
    send_frame(8'h48, 1'b1, 1'b0);
    idle(20);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL par_good_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (perr_cnt - p0 !== 0) begin errors++; $display("FAIL par_good_perr got=%0d exp=0", perr_cnt - p0); end
    d0 = done_cnt; p0 = perr_cnt;
    send_frame(8'h48, 1'b1, 1'b1);
    idle(20);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL par_bad_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL par_bad_perr got=%0d exp=1", perr_cnt - p0); end
    checks++; if (bus.data_byte !== 8'h48) begin errors++; $display("FAIL par_bad_data got=%h exp=48", bus.data_byte); end
  endtask
`endif

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
